// File: rtl/ps2_key_tracker_if.sv
// Byte handshake between the PS/2 receiver FIFO (master) and the key tracker (slave).
interface ps2_key_tracker_if;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_overflow;
   logic       rx_nextdata_n;

   modport master (
      output rx_ready,
      output rx_data,
      output rx_overflow,
      input  rx_nextdata_n
   );

   modport slave (
      input  rx_ready,
      input  rx_data,
      input  rx_overflow,
      output rx_nextdata_n
   );
endinterface

// File: rtl/ps2_key_tracker.sv
// Turns raw PS/2 scan-code bytes into make/break key events with repeat suppression
// and a two-digit BCD count of new key presses.
module ps2_key_tracker #(
   parameter bit REPEAT_PULSE = 1'b0
) (
   input  logic                clock,
   input  logic                reset,
   ps2_key_tracker_if.slave    rx,
   output logic [7:0]          key_code_o,
   output logic                key_ext_o,
   output logic                key_down_o,
   output logic                key_valid_o,
   output logic [7:0]          press_cnt_o,
   output logic                disp_en_o,
   output logic                err_overflow_o
);

   typedef enum logic [1:0] {StIdle, StPop, StGap, StDecode} state_e;

   state_e     state_q, state_d;
   logic [7:0] byte_q, byte_d;
   logic       ext_pend_q, ext_pend_d;
   logic       brk_pend_q, brk_pend_d;
   logic       nextdata_n_q, nextdata_n_d;
   logic [7:0] key_code_q, key_code_d;
   logic       key_ext_q, key_ext_d;
   logic       held_q, held_d;
   logic       brk_evt_q, brk_evt_d;
   logic       key_valid_q, key_valid_d;
   logic [7:0] press_cnt_q, press_cnt_d;
   logic       err_ovf_q, err_ovf_d;

   logic       is_ignored;
   logic       is_match;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (rx.rx_ready) state_d = StPop;
         StPop:    state_d = StGap;
         StGap:    state_d = StDecode;
         StDecode: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   assign is_ignored = (byte_q == 8'h00) || (byte_q == 8'hAA) || (byte_q == 8'hFA) ||
                       (byte_q == 8'hFE) || (byte_q == 8'hFF);
   assign is_match   = ({ext_pend_q, byte_q} == {key_ext_q, key_code_q});

   always_comb begin
      byte_d       = byte_q;
      ext_pend_d   = ext_pend_q;
      brk_pend_d   = brk_pend_q;
      nextdata_n_d = 1'b1;
      key_code_d   = key_code_q;
      key_ext_d    = key_ext_q;
      held_d       = held_q;
      brk_evt_d    = 1'b0;
      key_valid_d  = 1'b0;
      press_cnt_d  = press_cnt_q;
      err_ovf_d    = err_ovf_q | rx.rx_overflow;

      if (state_q == StIdle && rx.rx_ready) begin
         byte_d       = rx.rx_data;
         nextdata_n_d = 1'b0;
      end

      if (state_q == StDecode) begin
         if (byte_q == 8'hE0) begin
            ext_pend_d = 1'b1;
         end else if (byte_q == 8'hF0) begin
            brk_pend_d = 1'b1;
         end else begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            if (is_ignored) begin
               // Controller replies and errors carry no key information.
            end else if (brk_pend_q) begin
               key_valid_d = 1'b1;
               brk_evt_d   = 1'b1;
               if (is_match && held_q) held_d = 1'b0;
            end else if (held_q && is_match) begin
               key_valid_d = REPEAT_PULSE;
            end else begin
               key_code_d  = byte_q;
               key_ext_d   = ext_pend_q;
               held_d      = 1'b1;
               key_valid_d = 1'b1;
               if (press_cnt_q[3:0] == 4'd9) begin
                  press_cnt_d[3:0] = 4'd0;
                  press_cnt_d[7:4] = (press_cnt_q[7:4] == 4'd9) ? 4'd0 : press_cnt_q[7:4] + 4'd1;
               end else begin
                  press_cnt_d[3:0] = press_cnt_q[3:0] + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         byte_q       <= 8'h00;
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
         nextdata_n_q <= 1'b1;
         key_code_q   <= 8'h00;
         key_ext_q    <= 1'b0;
         held_q       <= 1'b0;
         brk_evt_q    <= 1'b0;
         key_valid_q  <= 1'b0;
         press_cnt_q  <= 8'h00;
         err_ovf_q    <= 1'b0;
      end else begin
         byte_q       <= byte_d;
         ext_pend_q   <= ext_pend_d;
         brk_pend_q   <= brk_pend_d;
         nextdata_n_q <= nextdata_n_d;
         key_code_q   <= key_code_d;
         key_ext_q    <= key_ext_d;
         held_q       <= held_d;
         brk_evt_q    <= brk_evt_d;
         key_valid_q  <= key_valid_d;
         press_cnt_q  <= press_cnt_d;
         err_ovf_q    <= err_ovf_d;
      end
   end

   // A break event always reads as key-up for its pulse cycle, even if another key stays held.
   always_comb begin
      rx.rx_nextdata_n = nextdata_n_q;
      key_code_o       = key_code_q;
      key_ext_o        = key_ext_q;
      key_down_o       = held_q & ~brk_evt_q;
      key_valid_o      = key_valid_q;
      press_cnt_o      = press_cnt_q;
      disp_en_o        = held_q;
      err_overflow_o   = err_ovf_q;
   end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: a small FIFO model feeds scan-code bytes and
// outputs are compared against hand-computed values.
module tb_ps2_key_tracker;

   logic       clock;
   logic       reset;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_down;
   logic       key_valid;
   logic [7:0] press_cnt;
   logic       disp_en;
   logic       err_overflow;

   ps2_key_tracker_if bus ();

   ps2_key_tracker #(.REPEAT_PULSE(1'b0)) dut (
      .clock          (clock),
      .reset          (reset),
      .rx             (bus),
      .key_code_o     (key_code),
      .key_ext_o      (key_ext),
      .key_down_o     (key_down),
      .key_valid_o    (key_valid),
      .press_cnt_o    (press_cnt),
      .disp_en_o      (disp_en),
      .err_overflow_o (err_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [7:0] fifo[$];
   int         pop_cyc[$];
   int         val_cyc[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         npop = 0;
   int         nvalid = 0;
   int         nv0, np0;
   logic       pending_pop = 1'b0;
   logic       vdown = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sync_rx();
      bus.rx_ready = (fifo.size() != 0);
      bus.rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
   endtask

   // Receiver model: the FIFO advances on the edge that ends the low pop strobe.
   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (pending_pop && fifo.size() != 0) fifo.delete(0);
      pending_pop = (bus.rx_nextdata_n == 1'b0);
      if (pending_pop) begin
         npop++;
         pop_cyc.push_back(cyc);
      end
      if (key_valid) begin
         nvalid++;
         val_cyc.push_back(cyc);
         vdown = key_down;
      end
      sync_rx();
   endtask

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
      sync_rx();
   endtask

   task automatic send(input logic [7:0] b);
      push(b);
      repeat (5) tick();
   endtask

   task automatic press_release(input logic [7:0] b);
      send(b);
      send(8'hF0);
      send(b);
   endtask

   initial begin
      reset           = 1'b1;
      bus.rx_ready    = 1'b0;
      bus.rx_data     = 8'h00;
      bus.rx_overflow = 1'b0;
      repeat (2) tick();
      check("rst_nextdata_n", 32'(bus.rx_nextdata_n), 32'd1);
      check("rst_key_code", 32'(key_code), 32'h00);
      check("rst_key_down", 32'(key_down), 32'd0);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_press_cnt", 32'(press_cnt), 32'h00);
      check("rst_disp_en", 32'(disp_en), 32'd0);
      check("rst_err_ovf", 32'(err_overflow), 32'd0);
      check("rst_key_ext", 32'(key_ext), 32'd0);
      reset = 1'b0;
      repeat (2) tick();

      // Make then break of 1C
      nv0 = nvalid;
      send(8'h1C);
      check("mk1c_code", 32'(key_code), 32'h1C);
      check("mk1c_down", 32'(key_down), 32'd1);
      check("mk1c_cnt", 32'(press_cnt), 32'h01);
      check("mk1c_disp", 32'(disp_en), 32'd1);
      check("mk1c_vdown", 32'(vdown), 32'd1);
      send(8'hF0);
      send(8'h1C);
      check("bk1c_down", 32'(key_down), 32'd0);
      check("bk1c_disp", 32'(disp_en), 32'd0);
      check("bk1c_code", 32'(key_code), 32'h1C);
      check("bk1c_pulses", 32'(nvalid - nv0), 32'd2);

      // Typematic repeats are suppressed
      nv0 = nvalid;
      np0 = npop;
      send(8'h1B);
      send(8'h1B);
      send(8'h1B);
      send(8'hF0);
      send(8'h1B);
      check("rep_pulses", 32'(nvalid - nv0), 32'd2);
      check("rep_pops", 32'(npop - np0), 32'd5);
      check("rep_cnt", 32'(press_cnt), 32'h02);
      check("rep_down", 32'(key_down), 32'd0);

      // Extended key 75
      send(8'hE0);
      send(8'h75);
      check("e75_ext", 32'(key_ext), 32'd1);
      check("e75_code", 32'(key_code), 32'h75);
      check("e75_down", 32'(key_down), 32'd1);
      check("e75_cnt", 32'(press_cnt), 32'h03);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      check("e75_brk_down", 32'(key_down), 32'd0);
      check("e75_brk_vdown", 32'(vdown), 32'd0);
      send(8'hE0);
      send(8'h75);
      check("e75_again_cnt", 32'(press_cnt), 32'h04);
      nv0 = nvalid;
      send(8'h75);
      check("p75_new_ext", 32'(key_ext), 32'd0);
      check("p75_new_cnt", 32'(press_cnt), 32'h05);
      check("p75_new_pulse", 32'(nvalid - nv0), 32'd1);

      // Break of a key that is not held: pulse reads key-up, held key survives
      nv0 = nvalid;
      send(8'hF0);
      send(8'h1C);
      check("nmbrk_pulse", 32'(nvalid - nv0), 32'd1);
      check("nmbrk_vdown", 32'(vdown), 32'd0);
      check("nmbrk_down", 32'(key_down), 32'd1);
      check("nmbrk_disp", 32'(disp_en), 32'd1);
      check("nmbrk_code", 32'(key_code), 32'h75);
      send(8'hF0);
      send(8'h75);
      check("p75_brk_down", 32'(key_down), 32'd0);

      // Ignored bytes clear prefixes and make no event
      nv0 = nvalid;
      send(8'hAA);
      check("ign_pulse", 32'(nvalid - nv0), 32'd0);
      send(8'hE0);
      send(8'hAA);
      send(8'h75);
      check("ign_ext", 32'(key_ext), 32'd0);
      check("ign_cnt", 32'(press_cnt), 32'h06);
      send(8'hF0);
      send(8'h75);

      // BCD counting through 09->10 and 99->00
      repeat (3) press_release(8'h1C);
      check("bcd_09", 32'(press_cnt), 32'h09);
      press_release(8'h1C);
      check("bcd_10", 32'(press_cnt), 32'h10);
      repeat (89) press_release(8'h1C);
      check("bcd_99", 32'(press_cnt), 32'h99);
      press_release(8'h1C);
      check("bcd_wrap", 32'(press_cnt), 32'h00);

      // Three bytes queued with rx_ready held high
      pop_cyc.delete();
      val_cyc.delete();
      push(8'h34);
      push(8'h33);
      push(8'h3B);
      repeat (16) tick();
      check("b2b_pops", 32'(pop_cyc.size()), 32'd3);
      check("b2b_valids", 32'(val_cyc.size()), 32'd3);
      if (pop_cyc.size() == 3 && val_cyc.size() == 3) begin
         check("b2b_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd4);
         check("b2b_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd4);
         for (int i = 0; i < 3; i++) begin
            check("b2b_latency", 32'(val_cyc[i] - pop_cyc[i]), 32'd3);
         end
      end
      check("b2b_code", 32'(key_code), 32'h3B);
      check("b2b_cnt", 32'(press_cnt), 32'h03);

      // Asynchronous reset while in POP
      push(8'h4B);
      tick();
      check("pop_low", 32'(bus.rx_nextdata_n), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check("arst_nextdata_n", 32'(bus.rx_nextdata_n), 32'd1);
      check("arst_code", 32'(key_code), 32'h00);
      check("arst_down", 32'(key_down), 32'd0);
      check("arst_cnt", 32'(press_cnt), 32'h00);
      check("arst_disp", 32'(disp_en), 32'd0);
      tick();
      reset = 1'b0;
      fifo.delete();
      pending_pop = 1'b0;
      sync_rx();
      tick();

      // Half-received break prefix is discarded by reset
      send(8'hF0);
      #2;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      send(8'h1C);
      check("pfx_discard_down", 32'(key_down), 32'd1);
      check("pfx_discard_cnt", 32'(press_cnt), 32'h01);

      // Sticky overflow; FSM keeps working
      bus.rx_overflow = 1'b1;
      tick();
      bus.rx_overflow = 1'b0;
      tick();
      check("ovf_set", 32'(err_overflow), 32'd1);
      send(8'hF0);
      send(8'h1C);
      check("ovf_sticky", 32'(err_overflow), 32'd1);
      check("ovf_fsm_runs", 32'(key_down), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
